// File: rtl/swizzle_arbiter_pkg.sv
// Shared types and helpers for the swizzle arbiter: counter width, requester id,
// output-stage state encoding and a width-generic bit reversal.
package swizzle_pkg;

  localparam int SWZ_COUNT_W = 16;
  localparam int SWZ_NUM_REQ = 4;
  localparam int SWZ_MAX_W   = 64;

  typedef logic [$clog2(SWZ_NUM_REQ)-1:0] swz_id_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Reverses the low `width` bits of d; bits at and above `width` come back zero.
  function automatic logic [SWZ_MAX_W-1:0] bit_reverse(input logic [SWZ_MAX_W-1:0] d,
                                                       input int unsigned         width);
    logic [SWZ_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < width && i < SWZ_MAX_W; i++) begin
      r[i] = d[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/swizzle_arbiter_if.sv
// Requester-side and response-side handshake bundle of the swizzle arbiter.
// The slave modport is the arbiter; the master modport is the producer/consumer side.
interface swizzle_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_valid;
  logic [WIDTH-1:0]   req_data [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;

  logic               resp_valid;
  logic [WIDTH-1:0]   resp_data;
  logic [ID_W-1:0]    resp_id;
  logic               resp_ready;

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

endinterface

// File: rtl/swizzle_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ (also for non-power-of-two NUM_REQ).
module swizzle_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       any
);

  localparam int ID_W = $clog2(NUM_REQ);

  int idx;

  // Walk offsets from farthest to nearest so the closest request to ptr wins last.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/swizzle_arbiter.sv
// Round-robin shared bit-reversal stage: one granted word per cycle is reversed
// into a single registered output slot tagged with its requester index.
module swizzle_arbiter
  import swizzle_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  swizzle_arbiter_if.slave       bus,
  output logic [SWZ_COUNT_W-1:0] accept_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  out_state_e             state_q;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]       resp_data_q, resp_data_d;
  logic [ID_W-1:0]        resp_id_q, resp_id_d;
  logic [SWZ_COUNT_W-1:0] count_q, count_d;

  logic [NUM_REQ-1:0]     grant;
  logic                   any_req;
  logic                   can_load;
  logic                   accept;
  logic [WIDTH-1:0]       gnt_data;

  swizzle_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req      (bus.req_valid),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .grant_id (resp_id_d),
    .any      (any_req)
  );

  // The slot can take a new word when it is empty or being drained this cycle.
  assign can_load      = (state_q == OUT_EMPTY) || bus.resp_ready;
  assign accept        = any_req && can_load;
  assign bus.req_ready = {NUM_REQ{can_load}} & grant;

  assign gnt_data = bus.req_data[resp_id_d];
  assign rr_ptr_d = (resp_id_d == ID_W'(NUM_REQ - 1)) ? '0 : resp_id_d + 1'b1;
  assign count_d  = count_q + 1'b1;

  for (genvar b = 0; b < WIDTH; b++) begin : g_rev
    assign resp_data_d[b] = gnt_data[WIDTH-1-b];
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (reset) begin
      state_q     <= OUT_EMPTY;
      rr_ptr_q    <= '0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
      count_q     <= '0;
    end else begin
      case (state_q)
        OUT_EMPTY: if (accept)                     state_q <= OUT_FULL;
        OUT_FULL:  if (bus.resp_ready && !accept)  state_q <= OUT_EMPTY;
      endcase
      // Pointer, payload and count move only on accept; a stall leaves them untouched.
      if (accept) begin
        resp_data_q <= resp_data_d;
        resp_id_q   <= resp_id_d;
        rr_ptr_q    <= rr_ptr_d;
        count_q     <= count_d;
      end
    end
  end

  assign bus.resp_valid = (state_q == OUT_FULL);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign accept_count   = count_q;

endmodule

// File: tb/tb_swizzle_arbiter.sv
// Self-checking bench for swizzle_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a queue-free model.
module tb_swizzle_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] accept_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         m_ptr;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_id;
  int         m_count;

  swizzle_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

  swizzle_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clock        (clk),
    .reset        (rst),
    .bus          (bus.slave),
    .accept_count (accept_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = 0;
    m_count = 0;
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] ref_rev(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r = {r[W-2:0], d[i]};
    return r;
  endfunction

  // Called at a falling edge with inputs already applied; compares, then advances one clock.
  task automatic cycle(output bit acc, output int g);
    bit           can;
    logic [N-1:0] exp_ready;
    #1;
    g         = model_grant(bus.req_valid);
    can       = !m_valid || bus.resp_ready;
    exp_ready = '0;
    if (g >= 0 && can) exp_ready[g] = 1'b1;
    check("req_ready", bus.req_ready, exp_ready);
    check("resp_valid", bus.resp_valid, m_valid);
    if (m_valid) begin
      check("resp_data", bus.resp_data, m_data);
      check("resp_id", bus.resp_id, m_id);
    end
    check("accept_count", accept_count, m_count);
    acc = (g >= 0) && can;
    @(posedge clk);
    if (acc) begin
      m_data  = ref_rev(bus.req_data[g]);
      m_id    = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % N;
      m_count = (m_count + 1) % 65536;
    end else if (m_valid && bus.resp_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit         acc;
    int         g;
    int         exp_id [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_d  [5] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h80};

    bus.req_valid  = '0;
    for (int i = 0; i < N; i++) bus.req_data[i] = '0;
    bus.resp_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    #1;
    check("rst_valid", bus.resp_valid, 0);
    check("rst_data", bus.resp_data, 0);
    check("rst_id", bus.resp_id, 0);
    check("rst_count", accept_count, 0);
    cycle(acc, g);

    // Single requester, three words back to back
    bus.req_valid  = 4'b0001;
    bus.req_data[0] = 8'h01;
    bus.resp_ready = 1'b1;
    cycle(acc, g);
    #1;
    check("single_valid", bus.resp_valid, 1);
    check("single_data", bus.resp_data, 8'h80);
    check("single_id", bus.resp_id, 0);
    check("single_count", accept_count, 1);
    bus.req_data[0] = 8'hA5;
    cycle(acc, g);
    #1;
    check("single_a5", bus.resp_data, 8'hA5);
    bus.req_data[0] = 8'h0F;
    cycle(acc, g);
    #1;
    check("single_0f", bus.resp_data, 8'hF0);
    check("single_count3", accept_count, 3);
    bus.req_valid = '0;
    cycle(acc, g);

    // Full contention from pointer 0
    do_reset();
    bus.req_valid   = 4'b1111;
    bus.req_data[0] = 8'h01;
    bus.req_data[1] = 8'h02;
    bus.req_data[2] = 8'h04;
    bus.req_data[3] = 8'h08;
    bus.resp_ready  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(acc, g);
      #1;
      check("rr_id", bus.resp_id, exp_id[k]);
      check("rr_data", bus.resp_data, exp_d[k]);
    end

    // Backpressure with req 2 waiting
    bus.req_valid   = 4'b0100;
    bus.req_data[2] = 8'h33;
    bus.resp_ready  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle(acc, g);
      #1;
      check("bp_ready", bus.req_ready, 0);
      check("bp_id", bus.resp_id, 0);
      check("bp_data", bus.resp_data, 8'h80);
    end
    bus.resp_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.req_ready, 4'b0100);
    cycle(acc, g);
    #1;
    check("bp_release_id", bus.resp_id, 2);
    check("bp_release_data", bus.resp_data, 8'hCC);

    // Pointer skip and wrap (pointer now 3)
    bus.req_valid   = 4'b0010;
    bus.req_data[1] = 8'h81;
    cycle(acc, g);
    #1;
    check("skip_id", bus.resp_id, 1);
    check("skip_data", bus.resp_data, 8'h81);
    bus.req_valid   = 4'b1010;
    bus.req_data[3] = 8'h0C;
    cycle(acc, g);
    #1;
    check("wrap_first_id", bus.resp_id, 3);
    check("wrap_first_data", bus.resp_data, 8'h30);
    bus.req_valid = 4'b0010;
    cycle(acc, g);
    #1;
    check("wrap_second_id", bus.resp_id, 1);
    bus.req_valid = '0;
    cycle(acc, g);

    // Asynchronous reset while a result is held and the count is 7
    do_reset();
    bus.req_valid   = 4'b0001;
    bus.req_data[0] = 8'h3C;
    bus.resp_ready  = 1'b1;
    for (int k = 0; k < 7; k++) cycle(acc, g);
    #1;
    check("pre_rst_count", accept_count, 7);
    check("pre_rst_valid", bus.resp_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", bus.resp_valid, 0);
    check("async_rst_data", bus.resp_data, 0);
    check("async_rst_id", bus.resp_id, 0);
    check("async_rst_count", accept_count, 0);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    cycle(acc, g);
    #1;
    check("post_rst_count", accept_count, 1);
    check("post_rst_data", bus.resp_data, 8'h3C);

    // Randomized traffic with held-until-accepted requesters
    do_reset();
    bus.req_valid = '0;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 99) < 40) begin
          bus.req_valid[i] = 1'b1;
          bus.req_data[i]  = 8'($urandom);
        end
      end
      bus.resp_ready = ($urandom_range(0, 99) < 70);
      cycle(acc, g);
      if (acc) bus.req_valid[g] = 1'b0;
    end

    // Counter wrap under continuous contention
    do_reset();
    bus.req_valid  = 4'b1111;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < N; i++) bus.req_data[i] = 8'($urandom);
    for (int c = 0; c < 65535; c++) begin
      cycle(acc, g);
      if (acc) bus.req_data[g] = 8'($urandom);
    end
    #1;
    check("wrap_ffff", accept_count, 16'hFFFF);
    cycle(acc, g);
    #1;
    check("wrap_zero", accept_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
